// File: rtl/eth_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : eth_tx_pkg
// Description : Shared types and constants for the MII Ethernet transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
package eth_tx_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PREAMBLE = 3'd1,
    HEADER   = 3'd2,
    PAYLOAD  = 3'd3,
    FCS      = 3'd4,
    IFG      = 3'd5
  } eth_tx_state_t;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam int          PREAMBLE_LEN  = 8;
  localparam int          HEADER_LEN    = 14;
  localparam int          FCS_LEN       = 4;
  localparam logic [31:0] CRC_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
  // Byte/cycle counter width: covers 1500 payload bytes and the IFG cycle count
  localparam int          CNT_W         = 11;

endpackage
`default_nettype wire

// File: rtl/eth_crc32_nibble.sv
`default_nettype none
// ============================================================================
// Module      : eth_crc32_nibble
// Description : Combinational IEEE 802.3 CRC-32 step over one 4-bit input,
//               reflected form, data bit 0 entering first.
// Revision    : 1.0 - initial release
// ============================================================================
module eth_crc32_nibble
  import eth_tx_pkg::*;
(
  input  logic [31:0] i_crc,
  input  logic [3:0]  i_nib,
  output logic [31:0] o_crc
);

  // Shift the four data bits LSB first through the reflected LFSR
  always_comb begin
    o_crc = i_crc;
    for (int i = 0; i < 4; i++) begin
      if (o_crc[0] ^ i_nib[i]) begin
        o_crc = (o_crc >> 1) ^ CRC_POLY_REFL;
      end else begin
        o_crc = o_crc >> 1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ethernet_tx.sv
`default_nettype none
// ============================================================================
// Module      : ethernet_tx
// Description : MII (4-bit) Ethernet frame transmitter. Emits preamble/SFD,
//               fixed MAC header, fixed-length payload pulled from a FIFO,
//               and optionally the CRC-32 FCS. Low nibble of each byte first.
//               Build option: define ETH_TX_FCS_EN to generate the FCS field.
// Revision    : 1.0 - initial release
// ============================================================================
module ethernet_tx
  import eth_tx_pkg::*;
#(
  parameter logic [47:0] DST_MAC     = 48'hFF_FF_FF_FF_FF_FF,
  parameter logic [47:0] SRC_MAC     = 48'h00_0A_35_01_02_03,
  parameter logic [15:0] ETH_TYPE    = 16'h88B5,
  parameter int          PAYLOAD_LEN = 1024,
  parameter int          IFG_BYTES   = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] datain,
  output logic       data_request,
  input  logic       send_enale,
  output logic       tx_ctrl,
  output logic [3:0] phy_txd
);

  localparam logic [111:0]     c_hdr      = {DST_MAC, SRC_MAC, ETH_TYPE};
  localparam logic [CNT_W-1:0] c_pre_last = CNT_W'(PREAMBLE_LEN - 1);
  localparam logic [CNT_W-1:0] c_hdr_last = CNT_W'(HEADER_LEN - 1);
  localparam logic [CNT_W-1:0] c_pay_last = CNT_W'(PAYLOAD_LEN - 1);
  localparam logic [CNT_W-1:0] c_fcs_last = CNT_W'(FCS_LEN - 1);
  localparam logic [CNT_W-1:0] c_ifg_last = CNT_W'(2 * IFG_BYTES - 1);

  // r_state/r_cnt/r_nib describe the nibble currently on the MII pins
  eth_tx_state_t    r_state, w_state_nxt, w_after_state;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_nib, w_nib_nxt;
  logic             w_slot_last;
  logic [3:0]       r_pay_hi, w_pay_hi_nxt;
  logic             r_tx_ctrl, w_tx_ctrl_nxt;
  logic [3:0]       r_txd, w_txd_nxt;
  logic             r_req, w_req_nxt;
  logic [7:0]       w_byte;
  logic [3:0]       w_hdr_idx;

`ifdef ETH_TX_FCS_EN
  logic [31:0] r_crc, w_crc_upd, w_fcs;
  assign w_fcs = ~r_crc;
`endif

  // Advance the frame position by one nibble (or one IFG cycle)
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_nib_nxt     = r_nib;
    w_slot_last   = 1'b0;
    w_after_state = IDLE;
    case (r_state)
      PREAMBLE: begin w_slot_last = (r_cnt == c_pre_last); w_after_state = HEADER;  end
      HEADER:   begin w_slot_last = (r_cnt == c_hdr_last); w_after_state = PAYLOAD; end
`ifdef ETH_TX_FCS_EN
      PAYLOAD:  begin w_slot_last = (r_cnt == c_pay_last); w_after_state = FCS;     end
      FCS:      begin w_slot_last = (r_cnt == c_fcs_last); w_after_state = IFG;     end
`else
      PAYLOAD:  begin w_slot_last = (r_cnt == c_pay_last); w_after_state = IFG;     end
`endif
      default: ;
    endcase
    case (r_state)
      IDLE: begin
        if (send_enale) begin
          w_state_nxt = PREAMBLE;
          w_cnt_nxt   = '0;
          w_nib_nxt   = 1'b0;
        end
      end
      IFG: begin
        if (r_cnt == c_ifg_last) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
`ifdef ETH_TX_FCS_EN
      PREAMBLE, HEADER, PAYLOAD, FCS: begin
`else
      PREAMBLE, HEADER, PAYLOAD: begin
`endif
        if (r_nib) begin
          w_nib_nxt = 1'b0;
          if (w_slot_last) begin
            w_state_nxt = w_after_state;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end else begin
          w_nib_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
        w_nib_nxt   = 1'b0;
      end
    endcase
  end

  // Output nibble, enable and FIFO strobe for the position being entered
  always_comb begin
    w_tx_ctrl_nxt = 1'b0;
    w_txd_nxt     = 4'h0;
    w_req_nxt     = 1'b0;
    w_pay_hi_nxt  = r_pay_hi;
    w_byte        = 8'h00;
    w_hdr_idx     = 4'(HEADER_LEN - 1) - w_cnt_nxt[3:0];
    case (w_state_nxt)
      PREAMBLE: begin
        w_tx_ctrl_nxt = 1'b1;
        w_byte        = (w_cnt_nxt == c_pre_last) ? SFD_BYTE : PREAMBLE_BYTE;
        w_txd_nxt     = w_nib_nxt ? w_byte[7:4] : w_byte[3:0];
      end
      HEADER: begin
        w_tx_ctrl_nxt = 1'b1;
        w_byte        = c_hdr[{w_hdr_idx, 3'b000} +: 8];
        w_txd_nxt     = w_nib_nxt ? w_byte[7:4] : w_byte[3:0];
        // First fetch rides in the last header slot
        w_req_nxt     = !w_nib_nxt && (w_cnt_nxt == c_hdr_last);
      end
      PAYLOAD: begin
        w_tx_ctrl_nxt = 1'b1;
        if (w_nib_nxt) begin
          w_txd_nxt = r_pay_hi;
        end else begin
          // Slot start: the byte requested two cycles ago is on datain now
          w_txd_nxt    = datain[3:0];
          w_pay_hi_nxt = datain[7:4];
        end
        w_req_nxt = !w_nib_nxt && (w_cnt_nxt != c_pay_last);
      end
`ifdef ETH_TX_FCS_EN
      FCS: begin
        w_tx_ctrl_nxt = 1'b1;
        w_txd_nxt     = w_fcs[{w_cnt_nxt[1:0], w_nib_nxt, 2'b00} +: 4];
      end
`endif
      default: ;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_nib     <= 1'b0;
      r_pay_hi  <= 4'h0;
      r_tx_ctrl <= 1'b0;
      r_txd     <= 4'h0;
      r_req     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_nib     <= w_nib_nxt;
      r_pay_hi  <= w_pay_hi_nxt;
      r_tx_ctrl <= w_tx_ctrl_nxt;
      r_txd     <= w_txd_nxt;
      r_req     <= w_req_nxt;
    end
  end

`ifdef ETH_TX_FCS_EN
  eth_crc32_nibble u_crc (
    .i_crc (r_crc),
    .i_nib (w_txd_nxt),
    .o_crc (w_crc_upd)
  );

  // Running CRC over header and payload nibbles as they are registered out
  always_ff @(posedge clk) begin
    if (rst) begin
      r_crc <= CRC_INIT;
    end else if (w_state_nxt == PREAMBLE && w_cnt_nxt == c_pre_last) begin
      r_crc <= CRC_INIT;
    end else if (w_state_nxt == HEADER || w_state_nxt == PAYLOAD) begin
      r_crc <= w_crc_upd;
    end
  end
`endif

  assign tx_ctrl      = r_tx_ctrl;
  assign phy_txd      = r_txd;
  assign data_request = r_req;

endmodule
`default_nettype wire

// File: tb/tb_ethernet_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_ethernet_tx
// Description : Directed self-checking bench for ethernet_tx (PAYLOAD_LEN=46)
//               and for the eth_crc32_nibble step function. Expected frame
//               length and FCS follow the ETH_TX_FCS_EN build option.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ethernet_tx;
  import eth_tx_pkg::*;

  localparam int PAYLOAD_LEN = 46;
  localparam int IFG_BYTES   = 12;
`ifdef ETH_TX_FCS_EN
  localparam int FRAME_NIBS  = 2 * (8 + 14 + PAYLOAD_LEN + 4);
`else
  localparam int FRAME_NIBS  = 2 * (8 + 14 + PAYLOAD_LEN);
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] datain = 8'h39;
  logic       send_enale = 1'b0;
  logic       data_request, tx_ctrl;
  logic [3:0] phy_txd;

  ethernet_tx #(.PAYLOAD_LEN(PAYLOAD_LEN), .IFG_BYTES(IFG_BYTES)) dut (
    .clk          (clk),
    .rst          (rst),
    .datain       (datain),
    .data_request (data_request),
    .send_enale   (send_enale),
    .tx_ctrl      (tx_ctrl),
    .phy_txd      (phy_txd)
  );

  logic [31:0] crc_in = 32'h0;
  logic [3:0]  crc_nib = 4'h0;
  logic [31:0] crc_out;
  eth_crc32_nibble u_crc_ref (.i_crc(crc_in), .i_nib(crc_nib), .o_crc(crc_out));

  always #20 clk = ~clk;

  int         n_cmp = 0, n_err = 0;
  logic       s_tx, s_req;
  logic [3:0] s_txd;
  int         idle_viol = 0;
  bit         pending = 1'b0;
  bit         use_inc = 1'b0;
  logic [7:0] inc_val = 8'h00;
  logic [3:0] cap [0:255];
  int         cap_len, cap_req;
  logic [3:0] exp_nib [0:255];

  typedef struct { int idx; logic [3:0] nib; } vec_t;
  vec_t vec [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  // One clock: sample at the falling edge, then play the FIFO role
  task automatic step();
    @(negedge clk);
    s_tx  = tx_ctrl;
    s_txd = phy_txd;
    s_req = data_request;
    if (!s_tx && (s_txd != 4'h0 || s_req)) idle_viol++;
    if (pending) begin
      datain = use_inc ? inc_val : 8'h39;
      if (use_inc) inc_val = inc_val + 8'h01;
    end
    pending = s_req;
  endtask

  task automatic capture(input int drop_at);
    int guard = 0;
    cap_len = 0;
    cap_req = 0;
    while (!s_tx && guard < 200) begin
      step();
      guard++;
    end
    if (!s_tx) begin
      n_cmp++;
      n_err++;
      $display("FAIL frame start timeout: got no tx_ctrl, expected tx_ctrl within 200 cycles");
    end else begin
      while (s_tx && cap_len < 256) begin
        cap[cap_len] = s_txd;
        if (s_req) cap_req++;
        cap_len++;
        if (cap_len == drop_at) send_enale = 1'b0;
        step();
      end
    end
  endtask

  task automatic build_exp(input bit inc, input logic [7:0] start);
    logic [111:0] hdr;
    logic [7:0]   b;
    logic [31:0]  c;
    int           n;
    hdr = {48'hFF_FF_FF_FF_FF_FF, 48'h00_0A_35_01_02_03, 16'h88B5};
    c = 32'hFFFFFFFF;
    n = 0;
    for (int i = 0; i < 15; i++) begin exp_nib[n] = 4'h5; n++; end
    exp_nib[n] = 4'hD; n++;
    for (int i = 0; i < 14 + PAYLOAD_LEN; i++) begin
      if (i < 14) b = hdr[8*(13-i) +: 8];
      else        b = inc ? 8'(start + 8'(i - 14)) : 8'h39;
      exp_nib[n] = b[3:0]; n++;
      exp_nib[n] = b[7:4]; n++;
      c = c ^ {24'h0, b};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
`ifdef ETH_TX_FCS_EN
    c = ~c;
    for (int j = 0; j < 8; j++) begin exp_nib[n] = c[4*j +: 4]; n++; end
`endif
  endtask

  task automatic compare_frame(input string name);
    int bad = -1;
    check({name, " length"}, cap_len, FRAME_NIBS);
    check({name, " requests"}, cap_req, PAYLOAD_LEN);
    for (int i = 0; i < FRAME_NIBS; i++) begin
      if (bad < 0 && cap[i] !== exp_nib[i]) bad = i;
    end
    n_cmp++;
    if (bad >= 0) begin
      n_err++;
      $display("FAIL %s nibble %0d: got %0h, expected %0h", name, bad, cap[bad], exp_nib[bad]);
    end
  endtask

  task automatic quiet(input string name, input int cycles);
    int act = 0;
    for (int i = 0; i < cycles; i++) begin
      step();
      if (s_tx || s_txd != 4'h0 || s_req) act++;
    end
    check(name, act, 0);
  endtask

  initial begin
    int         gap;
    logic       pre_tx;
    logic [7:0] ch;
    logic [31:0] c;

    // Hand-computed nibble positions in a frame with datain = 8'h39
    vec = '{'{0, 4'h5}, '{14, 4'h5}, '{15, 4'hD}, '{16, 4'hF}, '{30, 4'hA},
            '{33, 4'h3}, '{40, 4'h8}, '{43, 4'hB}, '{44, 4'h9}, '{135, 4'h3}};

    // Reset, then idle with send_enale low
    rst = 1'b1;
    step();
    step();
    check("reset outputs", {27'h0, s_tx, s_txd, s_req}, 32'h0);
    rst = 1'b0;
    quiet("idle quiet", 20);

    // Single frame, constant payload byte
    build_exp(1'b0, 8'h00);
    send_enale = 1'b1;
    step();
    check("start latency", {27'h0, s_tx, s_txd}, 32'h15);
    send_enale = 1'b0;
    capture(0);
    compare_frame("frame1");
    for (int i = 0; i < 10; i++) begin
      check($sformatf("frame1 nib[%0d]", vec[i].idx), {28'h0, cap[vec[i].idx]}, {28'h0, vec[i].nib});
    end
    quiet("no restart", 40);

    // Distinct payload bytes expose fetch/latch timing
    use_inc = 1'b1;
    inc_val = 8'hA0;
    build_exp(1'b1, 8'hA0);
    send_enale = 1'b1;
    step();
    send_enale = 1'b0;
    capture(0);
    compare_frame("inc frame");
    use_inc = 1'b0;
    quiet("inc quiet", 30);

    // Back-to-back frames, then drop enable mid-payload of the second
    build_exp(1'b0, 8'h00);
    send_enale = 1'b1;
    capture(0);
    compare_frame("b2b A");
    gap = 1;
    while (!s_tx && gap < 100) begin
      step();
      if (!s_tx) gap++;
    end
    check("ifg gap", gap, 2 * IFG_BYTES + 1);
    capture(60);
    compare_frame("b2b B");
    quiet("after drop", 60);

    // Reset in the middle of the payload, then a fresh frame
    send_enale = 1'b1;
    for (int i = 0; i < 70; i++) step();
    pre_tx = s_tx;
    check("active before rst", {31'h0, pre_tx}, 32'h1);
    rst = 1'b1;
    step();
    check("rst mid-frame", {30'h0, s_tx, s_req}, 32'h0);
    rst = 1'b0;
    capture(1);
    compare_frame("post-rst frame");
    quiet("post-rst quiet", 30);

    // CRC step function against the standard check value
    c = 32'hFFFFFFFF;
    for (int i = 0; i < 9; i++) begin
      ch = 8'h31 + 8'(i);
      crc_in = c; crc_nib = ch[3:0]; #1; c = crc_out;
      crc_in = c; crc_nib = ch[7:4]; #1; c = crc_out;
    end
    check("crc32 123456789", ~c, 32'hCBF43926);

    check("txd/req while tx_ctrl low", idle_viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
